// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory for the M stage.
// RV32I byte/halfword/word loads and stores with a configurable access latency,
// a stall handshake to the pipeline and an error flag for bad accesses.
module data_memory_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH_BYTES  = 1024,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned INIT_PATTERN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  stall,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic                  err
);

  localparam int unsigned DepthWords = DEPTH_BYTES / 4;
  localparam int unsigned WidxW      = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam int unsigned MemBits    = 8 * DEPTH_BYTES;
  localparam int unsigned Aw1        = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    req_write_q;
  logic [2:0]              funct3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;

  // Power-up image: byte i holds i[7:0] when the pattern is enabled.
  function automatic logic [MemBits-1:0] init_image();
    logic [MemBits-1:0] img;
    img = '0;
    if (INIT_PATTERN == 1) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        img[8*i +: 8] = 8'(i);
      end
    end
    return img;
  endfunction

  // Storage is a flat little-endian byte vector; contents survive reset.
  logic [MemBits-1:0] mem_q = init_image();

  logic                  acc_write;
  logic [2:0]            acc_f3;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [2:0]            acc_size;
  logic [Aw1-1:0]        end_addr;
  logic                  illegal;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  acc_err;
  logic [WidxW-1:0]      word_idx;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           ld_data;
  logic [31:0]           wr_word;
  logic                  do_access;

  // With single-cycle latency the access edge is also the capture edge, so the
  // live inputs are used in IDLE and the captured request otherwise.
  always_comb begin
    if (state_q == StIdle) begin
      acc_write = req_write;
      acc_f3    = funct3;
      acc_addr  = addr;
      acc_wdata = wdata;
    end else begin
      acc_write = req_write_q;
      acc_f3    = funct3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  // Decode size and the three error classes; range check is done one bit wider
  // than the address so it can never wrap.
  always_comb begin
    case (acc_f3[1:0])
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
    if (acc_write) begin
      illegal = (acc_f3 >= 3'b011);
    end else begin
      illegal = (acc_f3[1:0] == 2'b11) || (acc_f3 == 3'b110);
    end
    misaligned   = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                   ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
    end_addr     = {1'b0, acc_addr} + Aw1'(acc_size);
    out_of_range = end_addr > Aw1'(DEPTH_BYTES);
    acc_err      = illegal | misaligned | out_of_range;
  end

  // Read the containing word, extract lanes, and build the merged store word.
  always_comb begin
    word_idx = acc_err ? '0 : acc_addr[WidxW+1:2];
    rd_word  = mem_q[{word_idx, 5'b00000} +: 32];
    rd_byte  = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    rd_half  = rd_word[{acc_addr[1], 4'b0000} +: 16];
    case (acc_f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = 32'h0;
    endcase
    wr_word = rd_word;
    case (acc_f3[1:0])
      2'b00:   wr_word[{acc_addr[1:0], 3'b000} +: 8] = acc_wdata[7:0];
      2'b01:   wr_word[{acc_addr[1], 4'b0000} +: 16] = acc_wdata[15:0];
      2'b10:   wr_word = acc_wdata;
      default: wr_word = rd_word;
    endcase
  end

  assign do_access = ((state_q == StIdle) && req_valid && (LATENCY == 1)) ||
                     ((state_q == StWait) && (cnt_q == 4'd1));

  assign stall = ((state_q == StIdle) && req_valid) || (state_q == StWait);

  // Memory write on the edge entering RESP; a reset in progress drops it.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_write && !acc_err) begin
      mem_q[{word_idx, 5'b00000} +: 32] <= wr_word;
    end
  end

  // Access FSM with request capture and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      req_write_q <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rvalid      <= 1'b0;
      rdata       <= 32'h0;
      err         <= 1'b0;
    end else begin
      rvalid <= do_access;
      if (do_access) begin
        rdata <= (acc_write || acc_err) ? 32'h0 : ld_data;
        err   <= acc_err;
      end
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_write_q <= req_write;
            funct3_q    <= funct3;
            addr_q      <= addr;
            wdata_q     <= wdata;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: two instances (latency 1 and 3), expected responses queued
// at issue time and compared by one monitor whenever rvalid is seen.
module tb_data_memory_ctrl;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, req_valid1, req_write1, stall1, rvalid1, err1;
  logic [2:0]  funct3_1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        rst3, req_valid3, req_write3, stall3, rvalid3, err3;
  logic [2:0]  funct3_3;
  logic [31:0] addr3, wdata3, rdata3;

  data_memory_ctrl #(
    .ADDR_WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(1), .INIT_PATTERN(1)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_write(req_write1),
    .funct3(funct3_1), .addr(addr1), .wdata(wdata1), .stall(stall1),
    .rvalid(rvalid1), .rdata(rdata1), .err(err1)
  );

  data_memory_ctrl #(
    .ADDR_WIDTH(32), .DEPTH_BYTES(1024), .LATENCY(3), .INIT_PATTERN(1)
  ) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_write(req_write3),
    .funct3(funct3_3), .addr(addr3), .wdata(wdata3), .stall(stall3),
    .rvalid(rvalid3), .rdata(rdata3), .err(err3)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e_mon;
  int   checks  = 0;
  int   errors  = 0;
  int   run1    = 0;
  int   run3    = 0;
  int   tmo_req = 0;
  bit   end_req = 1'b0;
  bit   done    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reset state, stall length per access, and scoreboard pops.
  always @(negedge clk) begin
    if (rst1) begin
      chk("rst1_rvalid", rvalid1, 0);
      chk("rst1_stall", stall1, 0);
      chk("rst1_rdata", rdata1, 0);
      chk("rst1_err", err1, 0);
      run1 = 0;
    end else if (rvalid1) begin
      chk("resp1_stall", stall1, 0);
      chk("resp1_stall_cycles", run1, 1);
      run1 = 0;
      chk("resp1_expected", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e_mon = q1.pop_front();
        chk("resp1_rdata", rdata1, e_mon.rdata);
        chk("resp1_err", err1, e_mon.err);
      end
    end else begin
      run1 = stall1 ? run1 + 1 : 0;
    end

    if (rst3) begin
      chk("rst3_rvalid", rvalid3, 0);
      chk("rst3_stall", stall3, 0);
      chk("rst3_rdata", rdata3, 0);
      chk("rst3_err", err3, 0);
      run3 = 0;
    end else if (rvalid3) begin
      chk("resp3_stall", stall3, 0);
      chk("resp3_stall_cycles", run3, 3);
      run3 = 0;
      chk("resp3_expected", q3.size() != 0, 1);
      if (q3.size() != 0) begin
        e_mon = q3.pop_front();
        chk("resp3_rdata", rdata3, e_mon.rdata);
        chk("resp3_err", err3, e_mon.err);
      end
    end else begin
      run3 = stall3 ? run3 + 1 : 0;
    end

    if (end_req && !done) begin
      chk("q1_drained", q1.size(), 0);
      chk("q3_drained", q3.size(), 0);
      chk("wait_timeouts", tmo_req, 0);
      done = 1'b1;
    end
  end

  // Present one access and hold it until its response cycle, as the pipeline does.
  task automatic issue(input int sel, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    bit   got;
    e.rdata = er;
    e.err   = ee;
    @(posedge clk);
    #1;
    if (sel == 1) begin
      req_valid1 = 1'b1; req_write1 = wr; funct3_1 = f3; addr1 = a; wdata1 = wd;
      q1.push_back(e);
    end else begin
      req_valid3 = 1'b1; req_write3 = wr; funct3_3 = f3; addr3 = a; wdata3 = wd;
      q3.push_back(e);
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      got = (sel == 1) ? rvalid1 : rvalid3;
    end
    if (!got) tmo_req++;
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    req_valid1 = 1'b0; req_write1 = 1'b0; funct3_1 = 3'b0; addr1 = '0; wdata1 = '0;
    req_valid3 = 1'b0; req_write3 = 1'b0; funct3_3 = 3'b0; addr3 = '0; wdata3 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst1 = 1'b0; rst3 = 1'b0;

    // Latency 1: loads, sign/zero extension, store forwarding, errors.
    issue(1, 0, F_W,  32'h008, 0, 32'h0B0A0908, 0);
    issue(1, 0, F_B,  32'h083, 0, 32'hFFFFFF83, 0);
    issue(1, 0, F_BU, 32'h083, 0, 32'h00000083, 0);
    issue(1, 0, F_HU, 32'h082, 0, 32'h00008382, 0);
    issue(1, 0, F_H,  32'h082, 0, 32'hFFFF8382, 0);
    issue(1, 1, F_H,  32'h006, 32'hABCD1234, 32'h0, 0);
    issue(1, 0, F_W,  32'h004, 0, 32'h12340504, 0);
    issue(1, 0, F_W,  32'h008, 0, 32'h0B0A0908, 0);
    issue(1, 0, F_W,  32'h002, 0, 32'h0, 1);
    issue(1, 1, F_W,  32'h3FE, 32'h0, 32'h0, 1);
    issue(1, 1, F_W,  32'h400, 32'hFFFFFFFF, 32'h0, 1);
    issue(1, 0, F_W,  32'h000, 0, 32'h03020100, 0);
    issue(1, 0, F_W,  32'h3FC, 0, 32'hFFFEFDFC, 0);
    issue(1, 0, F_H,  32'h3FE, 0, 32'hFFFFFFFE, 0);
    issue(1, 0, F_BU, 32'h3FF, 0, 32'h000000FF, 0);
    issue(1, 0, F_HU, 32'h3FF, 0, 32'h0, 1);
    issue(1, 0, F_B,  32'h400, 0, 32'h0, 1);
    issue(1, 0, F_W,  32'h80000000, 0, 32'h0, 1);
    issue(1, 0, 3'b011, 32'h000, 0, 32'h0, 1);
    issue(1, 0, 3'b110, 32'h000, 0, 32'h0, 1);
    issue(1, 1, 3'b100, 32'h020, 32'hFFFFFFFF, 32'h0, 1);
    issue(1, 0, F_W,  32'h020, 0, 32'h23222120, 0);
    issue(1, 1, F_B,  32'h010, 32'h00000055, 32'h0, 0);
    issue(1, 0, F_W,  32'h010, 0, 32'h13121155, 0);
    issue(1, 1, F_W,  32'h3FC, 32'h11223344, 32'h0, 0);
    issue(1, 0, F_W,  32'h3FC, 0, 32'h11223344, 0);
    issue(1, 0, F_B,  32'h3FD, 0, 32'h00000033, 0);
    issue(1, 0, F_H,  32'h3FE, 0, 32'h00001122, 0);
    idle(4);

    // Latency 3: request held through RESP must not be accepted twice.
    issue(3, 0, F_W, 32'h000, 0, 32'h03020100, 0);
    idle(6);

    // Latency 3: reset during WAIT abandons the store.
    @(posedge clk);
    #1;
    req_valid3 = 1'b1; req_write3 = 1'b1; funct3_3 = F_W; addr3 = 32'h0; wdata3 = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    rst3 = 1'b1;
    req_valid3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    issue(3, 0, F_W, 32'h000, 0, 32'h03020100, 0);
    issue(3, 0, F_W, 32'h008, 0, 32'h0B0A0908, 0);
    issue(3, 1, F_W, 32'h040, 32'hCAFEF00D, 32'h0, 0);
    issue(3, 0, F_H, 32'h042, 0, 32'hFFFFCAFE, 0);
    issue(3, 0, F_W, 32'h041, 0, 32'h0, 1);
    idle(6);

    end_req = 1'b1;
    wait (done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
